dac_sample_pacer: RTL
=====================

# dac_sample_pacer

Downstream stage of the RVMyth core. It consumes the core's 10-bit `out` bus and drives the 10-bit DAC input code at a programmable, uniform update rate. Each new core value is captured once, queued in a small FIFO, and released to the DAC on a pacing tick. A one-cycle strobe accompanies each update, and sticky flags report dropped samples (overflow) and missed updates (underrun).

## Interface
Parameters:
- `WIDTH`, 10: sample width; matches core `out`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DIV_W`, 8: width of the pacing divider.

Ports:
- `clk`  in  1: single clock; all state on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Assertion (0) clears all state immediately; release is sampled on the `clk` rising edge.
- `core_out`  in  WIDTH: sample from core `out`.
- `capture_en`  in  1: enables capture of new samples.
- `div`  in  DIV_W: pacing period minus one; one tick every `div+1` cycles.
- `clear_flags`  in  1: synchronous clear of `overflow` and `underrun`.
- `dac_code`  out  WIDTH: registered code to the DAC.
- `dac_strobe`  out  1: one-cycle pulse in the cycle after `dac_code` changes source.
- `fifo_count`  out  $clog2(DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky; a sample was dropped because the FIFO was full.
- `underrun`  out  1: sticky; a tick found the FIFO empty after the first sample was played.

## Operation
- **Input register:** `in_q <= core_out` every cycle.
- **Change detect:**
  - `last_q` holds the most recently pushed value; `last_v` flags that `last_q` is valid.
  - Push request = `capture_en & (!last_v | in_q != last_q)`.
  - On a push request, `last_q <= in_q` and `last_v <= 1`. This happens whether or not the FIFO accepts the sample, so a dropped value is not retried.
  - Repeated identical values are never queued.
- **FIFO:**
  - Circular buffer with read/write pointers of width `$clog2(DEPTH)` that wrap modulo `DEPTH`.
  - Empty when `count==0`; full when `count==DEPTH`.
  - The head is not fall-through.
- **Pacer:**
  - Counter `cnt` (DIV_W bits). Tick when `cnt >= div`.
  - On a tick, `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - `div=0` gives a tick every cycle. Lowering `div` below `cnt` forces a tick on the next cycle.
- **Pop:**
  - On a tick with `count>0`: `dac_code <= head`, advance the read pointer, set `primed <= 1`, and assert `dac_strobe` for that one cycle after the edge.
  - On a tick with `count==0`: hold `dac_code`, no strobe. If `primed`, set `underrun`.
- **Simultaneous push and pop:**
  - Both are always accepted when `count>0`, including when full; `count` is unchanged.
  - When empty, only the push takes effect.
  - A push while full with no pop is dropped and sets `overflow`.
- **Flags:** `clear_flags` clears `overflow` and `underrun`. A set event in the same cycle wins. `primed` is not cleared by `clear_flags`.
- **Reset (async, active-low):** clears `dac_code=0`, `dac_strobe=0`, `fifo_count=0`, `overflow=0`, `underrun=0`, `cnt=0`, `last_v=0`, `primed=0`, and both pointers. Asserting reset mid-operation discards all FIFO contents. The first post-reset sample is always queued, even if it equals the pre-reset value.

## Timing
- `core_out` stable before edge k:
  - `in_q` updates at edge k.
  - The FIFO write occurs at edge k+1, and `fifo_count` increments after k+1.
  - Earliest pop is at edge k+2, so `dac_code` and `dac_strobe` are valid after k+2.
  - Minimum latency from `core_out` to `dac_code` is 3 edges.
- `dac_strobe` is high for exactly one cycle per popped sample. With `div=0` it may be continuously high across back-to-back pops.
- Spacing between strobes is ≥ `div+1` cycles; it equals `div+1` while the FIFO is non-empty.
- `fifo_count`, `overflow` and `underrun` are registered outputs, updated on the same edge as the event.

## Test plan
- **Reset:** hold `reset=0` for 10 cycles with a toggling `core_out` -> all outputs 0, no strobe. Assert `reset=0` mid-burst -> outputs clear within the same cycle, without waiting for a clock edge.
- **Latency:** `div=0`, `capture_en=1`, `core_out` 0→0x155 before edge k -> `dac_code=0x155` and a single strobe after edge k+2; `fifo_count` returns to 0.
- **Pacing:** `div=3`, push 0x001, 0x002, 0x003, 0x004 on consecutive cycles -> four strobes exactly 4 cycles apart, codes in order; `underrun` is set at the first empty tick afterwards.
- **Duplicate suppression:** hold `core_out=0x2AA` for 20 cycles, then change to 0x2AB -> exactly 2 pushes and 2 strobes.
- **Overflow and wrap:**
  - `div=255`, push `DEPTH+2` distinct values -> `fifo_count=DEPTH`, `overflow=1`; the dropped values are the last 2.
  - Drain -> the first `DEPTH` values pop in order.
  - Refill twice more -> pointers wrap and ordering is preserved.
- **Flags and simultaneous events:**
  - With the FIFO full, push on a tick cycle -> `count` stays `DEPTH` and no overflow.
  - `clear_flags` asserted on the same cycle as a new overflow -> `overflow` stays 1.
  - `clear_flags` alone -> both flags go to 0.

Source files
------------

// File: rtl/dac_sample_pacer.sv
// ---------------------------------------------------------------------------
// dac_sample_pacer
//
// Takes the RVMyth core's 10-bit `out` bus and plays it into a DAC at a
// uniform, programmable update rate. Each distinct core value is captured
// once and queued in a small circular FIFO. A pacing divider releases the
// queued values to the DAC one per tick.
//
// Ports
//   clk          in   single clock, all state on the rising edge
//   reset        in   asynchronous active-low reset
//   core_out     in   WIDTH  sample from the core
//   capture_en   in   enables capture of new samples
//   div          in   DIV_W  pacing period minus one (tick every div+1 cycles)
//   clear_flags  in   synchronous clear of overflow/underrun
//   dac_code     out  WIDTH  registered DAC input code
//   dac_strobe   out  one-cycle pulse after each dac_code update
//   fifo_count   out  $clog2(DEPTH)+1  current FIFO occupancy
//   overflow     out  sticky: a sample was dropped because the FIFO was full
//   underrun     out  sticky: a tick found the FIFO empty after playback began
// ---------------------------------------------------------------------------
module dac_sample_pacer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int DIV_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         core_out,
    input  logic                     capture_en,
    input  logic [DIV_W-1:0]         div,
    input  logic                     clear_flags,
    output logic [WIDTH-1:0]         dac_code,
    output logic                     dac_strobe,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Sample storage; read combinationally at the head, written on push.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] in_q_reg;
    logic [WIDTH-1:0] last_q_reg;
    logic             last_v_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [DIV_W-1:0] cnt_reg;
    logic             primed_reg;
    logic [WIDTH-1:0] dac_code_reg;
    logic             strobe_reg;
    logic             overflow_reg;
    logic             underrun_reg;

    logic push_req;
    logic push_ok;
    logic pop;
    logic tick;
    logic fifo_empty;
    logic fifo_full;
    logic ovf_set;
    logic unr_set;

    always_comb begin
        // last_v is cleared by reset so the first sample after reset is
        // always queued, even when it equals the value seen before reset.
        push_req   = capture_en & (~last_v_reg | (in_q_reg != last_q_reg));
        // ">=" rather than "==" so that lowering div below the running
        // count produces a tick on the next edge instead of a long wrap.
        tick       = (cnt_reg >= div);
        fifo_empty = (count_reg == '0);
        fifo_full  = (count_reg == FULL_COUNT);
        pop        = tick & ~fifo_empty;
        // A pop in the same cycle frees a slot, so a push is accepted even
        // when full as long as a pop happens alongside it.
        push_ok    = push_req & (~fifo_full | pop);
        ovf_set    = push_req & fifo_full & ~pop;
        unr_set    = tick & fifo_empty & primed_reg;

        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= in_q_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q_reg     <= '0;
            last_q_reg   <= '0;
            last_v_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            cnt_reg      <= '0;
            primed_reg   <= 1'b0;
            dac_code_reg <= '0;
            strobe_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            in_q_reg <= core_out;

            // The change detector advances on every request, accepted or
            // not, so a dropped value is never retried.
            if (push_req) begin
                last_q_reg <= in_q_reg;
                last_v_reg <= 1'b1;
            end

            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end

            if (tick) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + DIV_W'(1);
            end

            if (pop) begin
                dac_code_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                primed_reg   <= 1'b1;
            end
            strobe_reg <= pop;

            count_reg <= count_next;

            // A set event in the same cycle as clear_flags wins.
            overflow_reg <= ovf_set | (overflow_reg & ~clear_flags);
            underrun_reg <= unr_set | (underrun_reg & ~clear_flags);
        end
    end

    assign dac_code   = dac_code_reg;
    assign dac_strobe = strobe_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign underrun   = underrun_reg;

endmodule
